// File: rtl/sae_vigenere_if.sv
// sae_vigenere_if: request/response bundle for the sae_vigenere cipher engine.
//   master (stimulus side): drives mode, data_input, key_input, inputs_valid.
//   slave  (engine side)  : drives data_output, output_ready, key_loaded and
//                           the four one-cycle error pulses.
interface sae_vigenere_if;
    logic [1:0] mode;
    logic [7:0] data_input;
    logic [7:0] key_input;
    logic       inputs_valid;
    logic [7:0] data_output;
    logic       output_ready;
    logic       key_loaded;
    logic       err_invalid_ptxt_char;
    logic       err_invalid_seckey;
    logic       err_invalid_ctxt_char;
    logic       err_key_not_loaded;

    modport master (
        output mode, data_input, key_input, inputs_valid,
        input  data_output, output_ready, key_loaded, err_invalid_ptxt_char,
               err_invalid_seckey, err_invalid_ctxt_char, err_key_not_loaded
    );

    modport slave (
        input  mode, data_input, key_input, inputs_valid,
        output data_output, output_ready, key_loaded, err_invalid_ptxt_char,
               err_invalid_seckey, err_invalid_ctxt_char, err_key_not_loaded
    );
endinterface

// File: rtl/sae_vigenere.sv
// sae_vigenere: Vigenere letter cipher with a KEY_LEN-byte key.
//   clk   : rising-edge clock.
//   rst_n : asynchronous active-low reset.
//   bus   : sae_vigenere_if.slave
//           mode 00 resync use pointer, 01 load key byte, 10 encrypt, 11 decrypt.
//           Responses are registered (one-cycle latency); output_ready and err_*
//           are one-cycle pulses, key_loaded is a level, data_output holds.
module sae_vigenere #(
    parameter int KEY_LEN = 4,
    parameter int PTR_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    sae_vigenere_if.slave bus
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(KEY_LEN - 1);

    typedef enum logic [1:0] {
        ModeResync  = 2'b00,
        ModeKeyLoad = 2'b01,
        ModeEncrypt = 2'b10,
        ModeDecrypt = 2'b11
    } mode_e;

    // Valid key bytes are 1..25, so five bits per entry hold the whole range.
    logic [4:0]       r_key [KEY_LEN];
    logic [PTR_W-1:0] r_load_ptr;
    logic [PTR_W-1:0] r_use_ptr;
    logic             r_key_loaded;
    logic [7:0]       r_data_out;
    logic             r_out_ready;
    logic             r_err_ptxt;
    logic             r_err_seckey;
    logic             r_err_ctxt;
    logic             r_err_key_nl;

    mode_e      w_mode;
    logic       w_key_ok;
    logic       w_is_upper;
    logic       w_is_lower;
    logic       w_char_ok;
    logic [7:0] w_base;
    logic [4:0] w_offset;
    logic [4:0] w_key;
    logic [5:0] w_sum;
    logic [4:0] w_enc;
    logic [4:0] w_dec;
    logic [7:0] w_enc_char;
    logic [7:0] w_dec_char;

    assign w_mode     = mode_e'(bus.mode);
    assign w_key_ok   = (bus.key_input >= 8'd1) && (bus.key_input <= 8'd25);
    assign w_is_upper = (bus.data_input >= 8'h41) && (bus.data_input <= 8'h5A);
    assign w_is_lower = (bus.data_input >= 8'h61) && (bus.data_input <= 8'h7A);
    assign w_char_ok  = w_is_upper || w_is_lower;

    // Case is preserved by shifting relative to the letter's own base.
    assign w_base   = w_is_upper ? 8'h41 : 8'h61;
    assign w_offset = 5'(bus.data_input - w_base);
    assign w_key    = r_key[r_use_ptr];

    // Both operands are <= 25, so one conditional subtract/add completes mod 26.
    assign w_sum      = 6'(w_offset) + 6'(w_key);
    assign w_enc      = (w_sum >= 6'd26) ? 5'(w_sum - 6'd26) : 5'(w_sum);
    assign w_dec      = (w_offset >= w_key) ? (w_offset - w_key)
                                            : 5'(6'(w_offset) + 6'd26 - 6'(w_key));
    assign w_enc_char = w_base + {3'b000, w_enc};
    assign w_dec_char = w_base + {3'b000, w_dec};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key        <= '{default: '0};
            r_load_ptr   <= '0;
            r_use_ptr    <= '0;
            r_key_loaded <= 1'b0;
            r_data_out   <= '0;
            r_out_ready  <= 1'b0;
            r_err_ptxt   <= 1'b0;
            r_err_seckey <= 1'b0;
            r_err_ctxt   <= 1'b0;
            r_err_key_nl <= 1'b0;
        end else begin
            r_out_ready  <= 1'b0;
            r_err_ptxt   <= 1'b0;
            r_err_seckey <= 1'b0;
            r_err_ctxt   <= 1'b0;
            r_err_key_nl <= 1'b0;
            if (bus.inputs_valid) begin
                unique case (w_mode)
                    ModeResync: begin
                        r_use_ptr <= '0;
                    end
                    ModeKeyLoad: begin
                        if (w_key_ok) begin
                            r_key[r_load_ptr] <= bus.key_input[4:0];
                            if (r_load_ptr == LAST_PTR) begin
                                // Completion wins over the "new load" clear when KEY_LEN == 1.
                                r_key_loaded <= 1'b1;
                                r_load_ptr   <= '0;
                                r_use_ptr    <= '0;
                            end else begin
                                if (r_load_ptr == '0) begin
                                    r_key_loaded <= 1'b0;
                                end
                                r_load_ptr <= r_load_ptr + PTR_W'(1);
                            end
                        end else begin
                            r_err_seckey <= 1'b1;
                            r_load_ptr   <= '0;
                            r_key_loaded <= 1'b0;
                        end
                    end
                    ModeEncrypt, ModeDecrypt: begin
                        r_out_ready <= 1'b1;
                        if (!r_key_loaded) begin
                            r_err_key_nl <= 1'b1;
                            r_data_out   <= '0;
                        end else if (!w_char_ok) begin
                            r_err_ptxt <= (w_mode == ModeEncrypt);
                            r_err_ctxt <= (w_mode == ModeDecrypt);
                            r_data_out <= '0;
                        end else begin
                            r_data_out <= (w_mode == ModeEncrypt) ? w_enc_char : w_dec_char;
                            r_use_ptr  <= (r_use_ptr == LAST_PTR) ? '0
                                                                   : r_use_ptr + PTR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_output           = r_data_out;
    assign bus.output_ready          = r_out_ready;
    assign bus.key_loaded            = r_key_loaded;
    assign bus.err_invalid_ptxt_char = r_err_ptxt;
    assign bus.err_invalid_seckey    = r_err_seckey;
    assign bus.err_invalid_ctxt_char = r_err_ctxt;
    assign bus.err_key_not_loaded    = r_err_key_nl;

endmodule
